pattern_stream_ctrl: RTL
========================

Name: pattern_stream_ctrl

Overview:
- Sequencer that feeds parallel words, one bit per clock, into the dual serial pattern detector (Mealy hit `x`, Moore hit `y`).
- Holds the detector in reset between words, then releases it and shifts the word out on `ser_o`.
- Counts `x`/`y` hits and records the first `x` hit position.
- Returns a per-word result over a valid/ready handshake; sits between a word-stream source and the detector instance.

Parameters:
- WIDTH, 8: bits per word; >= 2.
- CNT_W, 4: hit-counter width; counters saturate at 2^CNT_W-1.
- MSB_FIRST, 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- IDX_W, $clog2(WIDTH)+1: width of the first-hit index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- word_valid_i  in  1  source word valid.
- word_data_i  in  WIDTH  source word.
- word_ready_o  out  1  controller can accept a word.
- det_rst_o  out  1  active-low reset to the detector.
- ser_o  out  1  serial bit to detector `in_i`.
- ser_en_o  out  1  high while `ser_o` carries a real word bit.
- x_i  in  1  detector `x` (combinational from `ser_o` plus detector state).
- y_i  in  1  detector `y` (registered, Moore).
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumer ready.
- res_x_cnt_o  out  CNT_W  `x` hits in the word.
- res_y_cnt_o  out  CNT_W  `y` hits in the word.
- res_xfirst_o  out  IDX_W  shift index (0 = first bit shifted) of the first `x` hit; WIDTH if none.

Behaviour:
- **Reset** (rst=0, immediate): state=IDLE, shift reg=0, bit cnt=0, counters=0, y_pend=0.
  - Outputs: res_valid_o=0, res_x_cnt_o=0, res_y_cnt_o=0, res_xfirst_o=WIDTH, ser_o=0, ser_en_o=0, det_rst_o=0.
  - word_ready_o=1 once rst=1.
- All control outputs decode from registered state only; `ser_o` is the registered shift-register head.
- **IDLE**
  - word_ready_o=1, det_rst_o=0 (detector held in reset).
  - On word_valid_i=1 (accept edge): load the word, clear counters, set res_xfirst=WIDTH, set bit cnt=0, go to SHIFT.
  - det_rst_o goes high on the same edge, so the detector leaves reset one full cycle before its first data edge.
- **SHIFT** (exactly WIDTH cycles)
  - ser_en_o=1, det_rst_o=1; `ser_o`=current bit; the register shifts toward the head each edge.
  - `x_i` is sampled every SHIFT cycle. If 1: increment x_cnt (saturating); if res_xfirst==WIDTH, load the current bit index.
  - `y_i` reflects the bit shifted on the previous edge, so it is sampled only when y_pend=1. y_pend is a register equal to the previous cycle's ser_en_o.
  - After bit index WIDTH-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - ser_en_o=0, det_rst_o=1; `ser_o` don't-care (pad 0).
  - Sample `y_i` for the last bit; `x_i` is ignored.
  - Go to REPORT.
- **REPORT**
  - res_valid_o=1; counts and index held stable; word_ready_o=0; det_rst_o=0.
  - Return to IDLE on the edge where res_ready_i=1.
- **Latency:** res_valid_o rises WIDTH+1 edges after the accept edge. Minimum word period is WIDTH+3 cycles.
- **Backpressure:** with res_ready_i held low, REPORT persists indefinitely with all result outputs constant. No word is accepted during SHIFT, DRAIN or REPORT.
- **Saturation:** counters stick at 2^CNT_W-1. Widths are otherwise unsigned with no wrap.
- **Reset mid-operation:** immediate return to reset values; the partial word is discarded and no result is issued.
- word_valid_i/word_data_i are sampled only in IDLE. Changes in other states have no effect.

Test Plan:
- Reset then idle: rst low 3 cycles, then high -> word_ready_o=1, det_rst_o=0, res_valid_o=0, res_xfirst_o=8, ser_en_o=0.
- Word 8'h5A (MSB_FIRST=1) -> ser_o sequence 0,1,0,1,1,0,1,0 with ser_en_o high 8 cycles; res_valid_o 9 edges after accept; x_cnt=4, y_cnt=1, xfirst=2.
- Word 8'h22 -> x_cnt=2, y_cnt=2, xfirst=3. Then 8'h00 and 8'hFF back-to-back -> both x_cnt=0, y_cnt=0, xfirst=8; each word period 11 cycles.
- CNT_W=2, word 8'h5A -> x_cnt saturates at 3, y_cnt=1.
- res_ready_i held low 20 cycles after 8'h5A with word_valid_i=1 and new data -> result stable, word_ready_o=0, no second accept until the ready handshake; the next word is accepted in the following IDLE.
- rst asserted at the 4th SHIFT cycle -> all outputs return to reset values at once; after release, word 8'h22 produces x_cnt=2, y_cnt=2 with no carry-over.

Source files
------------

// File: rtl/pattern_stream_ctrl_if.sv
// pattern_stream_ctrl_if: word-in / result-out handshake bundle of the pattern stream sequencer.
interface pattern_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = $clog2(WIDTH) + 1
);
  logic             word_valid_i;
  logic [WIDTH-1:0] word_data_i;
  logic             word_ready_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [CNT_W-1:0] res_x_cnt_o;
  logic [CNT_W-1:0] res_y_cnt_o;
  logic [IDX_W-1:0] res_xfirst_o;
  modport master (
    output word_valid_i, word_data_i, res_ready_i,
    input  word_ready_o, res_valid_o, res_x_cnt_o, res_y_cnt_o, res_xfirst_o
  );
  modport slave (
    input  word_valid_i, word_data_i, res_ready_i,
    output word_ready_o, res_valid_o, res_x_cnt_o, res_y_cnt_o, res_xfirst_o
  );
endinterface

// File: rtl/pattern_stream_ctrl.sv
// pattern_stream_ctrl: shifts words bit-serially into a dual pattern detector and reports x/y hit counts per word.
module pattern_stream_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = $clog2(WIDTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  pattern_stream_ctrl_if.slave       strm,
  output logic                       det_rst_o,
  output logic                       ser_o,
  output logic                       ser_en_o,
  input  logic                       x_i,
  input  logic                       y_i
);
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;
  localparam logic [IDX_W-1:0] NONE = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IDX_W-1:0] bit_q, bit_d, xfirst_q, xfirst_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic             y_pend_q;
  logic             accept, x_hit, y_hit;
  assign accept = (state_q == IDLE) && strm.word_valid_i;
  assign x_hit  = (state_q == SHIFT) && x_i;
  // y is a registered detector output, so it trails ser_o by one cycle
  assign y_hit  = y_pend_q && y_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (strm.word_valid_i) state_d = SHIFT;
      SHIFT:  if (bit_q == LAST) state_d = DRAIN;
      DRAIN:  state_d = REPORT;
      REPORT: if (strm.res_ready_i) state_d = IDLE;
    endcase
  end
  always_comb begin
    strm.word_ready_o = state_q == IDLE;
    strm.res_valid_o  = state_q == REPORT;
    ser_en_o          = state_q == SHIFT;
    det_rst_o         = (state_q == SHIFT) || (state_q == DRAIN);
  end
  always_comb begin
    sh_d     = accept ? strm.word_data_i
             : (state_q == SHIFT) ? (MSB_FIRST ? sh_q << 1 : sh_q >> 1) : sh_q;
    bit_d    = accept ? '0 : (state_q == SHIFT) ? bit_q + IDX_W'(1) : bit_q;
    x_cnt_d  = accept ? '0 : (x_hit && x_cnt_q != SAT) ? x_cnt_q + CNT_W'(1) : x_cnt_q;
    y_cnt_d  = accept ? '0 : (y_hit && y_cnt_q != SAT) ? y_cnt_q + CNT_W'(1) : y_cnt_q;
    xfirst_d = accept ? NONE : (x_hit && xfirst_q == NONE) ? bit_q : xfirst_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q     <= '0;
      bit_q    <= '0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      xfirst_q <= NONE;
      y_pend_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      xfirst_q <= xfirst_d;
      y_pend_q <= ser_en_o;
    end
  end
  assign ser_o             = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign strm.res_x_cnt_o  = x_cnt_q;
  assign strm.res_y_cnt_o  = y_cnt_q;
  assign strm.res_xfirst_o = xfirst_q;
endmodule
